clk_edge_monitor: RTL and testbench
===================================

# clk_edge_monitor

Consumes a slow clock or strobe, such as a divided clock from a counter divider or an external reference, and turns it into single-cycle enable pulses in the fast `clk` domain. It also measures the slow signal's period in fast cycles, reports when that period has locked, and flags loss of the slow signal. It is the receiving end of a divided-clock output: downstream logic stays on `clk` and uses `rise_pulse` / `fall_pulse` as clock enables instead of clocking flops from a derived clock.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops on `slow_in`; minimum 2.
- `CNT_W`, 8: width of the period counter and `period` output.
- `LOCK_CNT`, 4: consecutive in-tolerance periods required to assert `locked`; range 1..15.
- `TIMEOUT`, 255: fast cycles without a rising edge before `lost` asserts; must be ≤ 2^CNT_W − 1.
- `clk` input 1: fast system clock; all logic on posedge.
- `rst` input 1: synchronous reset, active-high.
- `slow_in` input 1: slow clock or strobe; may be asynchronous to `clk`.
- `rise_pulse` output 1: one-cycle pulse per accepted rising edge.
- `fall_pulse` output 1: one-cycle pulse per accepted falling edge.
- `period` output CNT_W: last measured rising-to-rising distance, in `clk` cycles.
- `locked` output 1: period stable within ±1 for `LOCK_CNT` consecutive periods.
- `lost` output 1: no rising edge for `TIMEOUT` cycles; sticky until the next rising edge.

## Operation
- **Synchronizer:** `SYNC_STAGES` flops feed a level register `lvl`, which holds the last accepted level.
  - Edge accepted when the synchronized value differs from `lvl`.
  - Rising edge: `rise_pulse` high for exactly one cycle. Falling edge: `fall_pulse` high for exactly one cycle.
  - `rise_pulse` and `fall_pulse` are never high in the same cycle.
- **Period counter `cnt`:**
  - Clears to 0 in the cycle `rise_pulse` is high, and increments otherwise.
  - Saturates at `TIMEOUT`; never wraps.
  - On each rising edge after the first, `period <= cnt + 1`. A divide-by-8 input therefore gives `period` = 8.
- **FSM states:** IDLE, MEASURE, TRACK, LOCKED.
  - IDLE: waiting for the first rise. First rise → MEASURE; `period` unchanged.
  - MEASURE: next rise captures `period`, match count ← 0 → TRACK.
  - TRACK: on each rise, if |new − `period`| ≤ 1, match count +1, else match count ← 0. `period` is updated on every rise. When match count reaches `LOCK_CNT` → LOCKED.
  - LOCKED: an in-tolerance rise stays in LOCKED. An out-of-tolerance rise → TRACK with match count 0.
  - Any state except IDLE: `cnt` reaching `TIMEOUT` → IDLE.
- **`locked`:** high only in LOCKED; it is a registered state decode.
- **`lost`:**
  - Sets in the cycle `cnt` reaches `TIMEOUT`, including from IDLE after reset, so a dead input is flagged.
  - Clears in the cycle of the next `rise_pulse`.
  - If the timeout and a rise occur in the same cycle, the rise wins: `lost` stays clear and `cnt` clears.
- **Reset:** `rst` high in any cycle gives, on the next edge:
  - all outputs 0, `period` 0, `cnt` 0, FSM IDLE.
  - synchronizer flops and `lvl` loaded with 0, so a high `slow_in` at reset release yields one `rise_pulse`.

## Timing
- Latency from a `slow_in` transition, first sampled at edge k, to its pulse: pulse high after edge k+SYNC_STAGES.
- The pulse is registered; there is no combinational path from `slow_in` to any output.
- `period` and the FSM update on the same edge that raises `rise_pulse`. `locked` changes on that edge.
- Minimum resolvable `slow_in` high or low time is 1 `clk` cycle without the filter and 2 with it.
- Throughput: a rise and a fall can be accepted on consecutive cycles.

## Configuration
- **`CLK_MON_GLITCH_FILTER_EN` defined:**
  - one extra filter flop after the synchronizer.
  - A level is accepted only if the synchronized value is equal on 2 consecutive cycles.
  - Pulses shorter than 2 cycles are suppressed entirely.
  - Adds 1 cycle to pulse latency.
- **Not defined:** no filter flop; single-cycle levels are accepted.

## Structure
- Shared package `clk_mon_pkg`:
  - FSM state encoding (`ST_IDLE`, `ST_MEASURE`, `ST_TRACK`, `ST_LOCKED`)
  - tolerance constant `PERIOD_TOL = 1`.
- Sub-module `clk_mon_sync`: parameterized `SYNC_STAGES` synchronizer, plus the optional filter under the macro. Outputs the clean level only.
- Edge detect, counter and FSM stay in the top module.

## Test plan
- `slow_in` = divide-by-8 of `clk`:
  - `rise_pulse` every 8 cycles, `period` = 8.
  - `locked` rises on the rise after 1 + 1 + `LOCK_CNT` rises, i.e. the 6th rise with defaults.
  - `fall_pulse` 4 cycles after each rise.
- Lock, then hold `slow_in` low:
  - `lost` = 1 and `locked` = 0 exactly 255 cycles after the last rise.
  - the next rise clears `lost`; the FSM is in MEASURE.
- Locked at 8, switch the input to period 12: `locked` drops on the first 12-cycle rise and relocks after `LOCK_CNT` further 12-cycle periods.
- Alternate periods 8 and 9, then 8 and 10:
  - 8/9 stays locked (within tolerance).
  - 8/10 never asserts `locked`.
- Assert `rst` for 1 cycle mid-LOCKED:
  - next cycle all outputs 0 and `period` 0.
  - with `slow_in` high at release, exactly one `rise_pulse` at SYNC_STAGES+1 cycles after release.
- 1-cycle high glitch on `slow_in`:
  - without the macro: one `rise_pulse` and one `fall_pulse`.
  - with `CLK_MON_GLITCH_FILTER_EN`: no pulses, `period` unchanged.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// clk_edge_monitor shared types: FSM encoding and period tolerance.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  localparam int PERIOD_TOL = 1;

endpackage

// File: rtl/clk_mon_sync.sv
// Synchronizer for the slow input; optional glitch filter flop
// enabled by CLK_MON_GLITCH_FILTER_EN.
module clk_mon_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_level
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

`ifdef CLK_MON_GLITCH_FILTER_EN
  logic r_filt;

  // accept a level only once the last two stages agree
  always_ff @(posedge clk) begin
    if (rst)
      r_filt <= 1'b0;
    else if (r_sync[SYNC_STAGES-1] == r_sync[SYNC_STAGES-2])
      r_filt <= r_sync[SYNC_STAGES-1];
  end

  assign o_level = r_filt;
`else
  assign o_level = r_sync[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/clk_edge_monitor.sv
// Slow clock/strobe to fast-domain enables, period measure, lock, loss.
// Glitch filter selectable with CLK_MON_GLITCH_FILTER_EN.
module clk_edge_monitor
  import clk_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int LOCK_CNT    = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             locked,
  output logic             lost
);

  localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TOL  = CNT_W'(PERIOD_TOL);
  localparam logic [3:0]       LOCK = 4'(LOCK_CNT);

  logic             w_level;
  logic             w_rise;
  logic             w_fall;
  logic [CNT_W-1:0] w_meas;
  logic [CNT_W-1:0] w_diff;
  logic             w_in_tol;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_period_nxt;
  logic [3:0]       w_match_nxt;
  logic             w_lost_nxt;
  state_t           w_state_nxt;

  logic             r_lvl;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [3:0]       r_match;
  logic             r_lost;
  logic             r_locked;
  state_t           r_state;

  clk_mon_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_d    (slow_in),
    .o_level(w_level)
  );

  assign w_rise = w_level & ~r_lvl;
  assign w_fall = ~w_level & r_lvl;

  assign w_meas = r_cnt + CNT_W'(1);
  assign w_diff = (w_meas >= r_period) ? (w_meas - r_period)
                                       : (r_period - w_meas);
  assign w_in_tol = (w_diff <= TOL);

  always_comb begin
    w_state_nxt  = r_state;
    w_match_nxt  = r_match;
    w_period_nxt = r_period;
    w_lost_nxt   = r_lost;
    w_cnt_nxt    = (r_cnt == TMO) ? r_cnt : w_meas;
    // a rise in the timeout cycle takes priority
    if (w_rise) begin
      w_cnt_nxt  = '0;
      w_lost_nxt = 1'b0;
      unique case (r_state)
        ST_IDLE: w_state_nxt = ST_MEASURE;
        ST_MEASURE: begin
          w_period_nxt = w_meas;
          w_match_nxt  = 4'd0;
          w_state_nxt  = ST_TRACK;
        end
        ST_TRACK: begin
          w_period_nxt = w_meas;
          if (w_in_tol) begin
            w_match_nxt = r_match + 4'd1;
            if (r_match + 4'd1 == LOCK)
              w_state_nxt = ST_LOCKED;
          end else begin
            w_match_nxt = 4'd0;
          end
        end
        ST_LOCKED: begin
          w_period_nxt = w_meas;
          if (!w_in_tol) begin
            w_match_nxt = 4'd0;
            w_state_nxt = ST_TRACK;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (w_cnt_nxt == TMO) begin
      w_lost_nxt  = 1'b1;
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_lvl    <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_cnt    <= '0;
      r_period <= '0;
      r_match  <= 4'd0;
      r_lost   <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_lvl    <= w_level;
      r_rise   <= w_rise;
      r_fall   <= w_fall;
      r_cnt    <= w_cnt_nxt;
      r_period <= w_period_nxt;
      r_match  <= w_match_nxt;
      r_lost   <= w_lost_nxt;
      r_locked <= (w_state_nxt == ST_LOCKED);
    end
  end

  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign period     = r_period;
  assign locked     = r_locked;
  assign lost       = r_lost;

endmodule

// File: tb/tb_clk_edge_monitor.sv
// Directed self-checking bench for clk_edge_monitor.
module tb_clk_edge_monitor;
  import clk_mon_pkg::*;

`ifdef CLK_MON_GLITCH_FILTER_EN
  localparam int LAT  = 3;
  localparam int FILT = 1;
`else
  localparam int LAT  = 2;
  localparam int FILT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       slow_in;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [7:0] period;
  logic       locked;
  logic       lost;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  clk_edge_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .slow_in   (slow_in),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .period    (period),
    .locked    (locked),
    .lost      (lost)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    slow_in = 1'b0;
    rst     = 1'b1;
    cyc();
    rst     = 1'b0;
  endtask

  task automatic run_period(input int h, input int l);
    slow_in = 1'b1;
    repeat (h) cyc();
    slow_in = 1'b0;
    repeat (l) cyc();
  endtask

  task automatic test_reset();
    slow_in = 1'b0;
    rst     = 1'b1;
    cyc();
    cyc();
    rst     = 1'b0;
    n_tests += 5;
    if (rise_pulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_rise: got %b want 0", rise_pulse);
    end
    if (fall_pulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_fall: got %b want 0", fall_pulse);
    end
    if (period !== 8'd0) begin
      n_fail++; $display("FAIL reset_period: got %0d want 0", period);
    end
    if (locked !== 1'b0) begin
      n_fail++; $display("FAIL reset_locked: got %b want 0", locked);
    end
    if (lost !== 1'b0) begin
      n_fail++; $display("FAIL reset_lost: got %b want 0", lost);
    end
  endtask

  task automatic test_dead_input();
    do_reset();
    for (int i = 1; i <= 257; i++) begin
      cyc();
      n_tests++;
      if (lost !== logic'(i >= 255)) begin
        n_fail++;
        $display("FAIL dead_lost cyc %0d: got %b want %b",
                 i, lost, i >= 255);
      end
    end
  endtask

  task automatic test_div8();
    logic       er, ef, el;
    logic [7:0] ep;
    do_reset();
    for (int c = 0; c < 64; c++) begin
      slow_in = logic'((c % 8) < 4);
      cyc();
      er = (c >= LAT) && (((c - LAT) % 8) == 0);
      ef = (c >= LAT) && (((c - LAT) % 8) == 4);
      el = (c >= LAT + 40);
      ep = (c >= LAT + 8) ? 8'd8 : 8'd0;
      n_tests += 5;
      if (rise_pulse !== er) begin
        n_fail++;
        $display("FAIL div8_rise c %0d: got %b want %b", c, rise_pulse, er);
      end
      if (fall_pulse !== ef) begin
        n_fail++;
        $display("FAIL div8_fall c %0d: got %b want %b", c, fall_pulse, ef);
      end
      if (locked !== el) begin
        n_fail++;
        $display("FAIL div8_locked c %0d: got %b want %b", c, locked, el);
      end
      if (period !== ep) begin
        n_fail++;
        $display("FAIL div8_period c %0d: got %0d want %0d", c, period, ep);
      end
      if ((rise_pulse & fall_pulse) !== 1'b0) begin
        n_fail++;
        $display("FAIL div8_both c %0d: got 1 want 0", c);
      end
    end
  endtask

  task automatic test_lost();
    int e0;
    int e;
    do_reset();
    repeat (6) run_period(4, 4);
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++; $display("FAIL lost_prelock: got %b want 1", locked);
    end
    e0 = 8 - (LAT + 1);
    slow_in = 1'b0;
    for (int i = 1; e0 + i <= 258; i++) begin
      e = e0 + i;
      cyc();
      n_tests += 2;
      if (lost !== logic'(e >= 255)) begin
        n_fail++;
        $display("FAIL lost_flag e %0d: got %b want %b", e, lost, e >= 255);
      end
      if (locked !== logic'(e < 255)) begin
        n_fail++;
        $display("FAIL lost_locked e %0d: got %b want %b", e, locked, e < 255);
      end
    end
    slow_in = 1'b1;
    for (int i = 1; i <= LAT + 1; i++) begin
      cyc();
      n_tests += 2;
      if (rise_pulse !== logic'(i == LAT + 1)) begin
        n_fail++;
        $display("FAIL lost_rise i %0d: got %b want %b",
                 i, rise_pulse, i == LAT + 1);
      end
      if (lost !== logic'(i <= LAT)) begin
        n_fail++;
        $display("FAIL lost_clear i %0d: got %b want %b", i, lost, i <= LAT);
      end
    end
    n_tests += 2;
    if (dut.r_state !== ST_MEASURE) begin
      n_fail++;
      $display("FAIL lost_state: got %0d want %0d", dut.r_state, ST_MEASURE);
    end
    if (period !== 8'd8) begin
      n_fail++; $display("FAIL lost_period: got %0d want 8", period);
    end
  endtask

  task automatic test_retrack();
    do_reset();
    repeat (6) run_period(4, 4);
    run_period(6, 6);
    n_tests += 2;
    if (locked !== 1'b1) begin
      n_fail++; $display("FAIL retrack_hold: got %b want 1", locked);
    end
    if (period !== 8'd8) begin
      n_fail++; $display("FAIL retrack_p8: got %0d want 8", period);
    end
    run_period(6, 6);
    n_tests += 2;
    if (locked !== 1'b0) begin
      n_fail++; $display("FAIL retrack_drop: got %b want 0", locked);
    end
    if (period !== 8'd12) begin
      n_fail++; $display("FAIL retrack_p12: got %0d want 12", period);
    end
    for (int j = 0; j < 4; j++) begin
      run_period(6, 6);
      n_tests++;
      if (locked !== logic'(j == 3)) begin
        n_fail++;
        $display("FAIL retrack_relock j %0d: got %b want %b",
                 j, locked, j == 3);
      end
    end
  endtask

  task automatic test_tolerance();
    do_reset();
    repeat (6) run_period(4, 4);
    for (int j = 0; j < 6; j++) begin
      run_period(4, (j % 2 == 0) ? 5 : 4);
      n_tests++;
      if (locked !== 1'b1) begin
        n_fail++; $display("FAIL tol89_locked j %0d: got %b want 1", j, locked);
      end
    end
    n_tests++;
    if (period !== 8'd9) begin
      n_fail++; $display("FAIL tol89_period: got %0d want 9", period);
    end
    do_reset();
    for (int j = 0; j < 12; j++) begin
      run_period((j % 2 == 1) ? 5 : 4, (j % 2 == 1) ? 5 : 4);
      n_tests++;
      if (locked !== 1'b0) begin
        n_fail++; $display("FAIL tol810_locked j %0d: got %b want 0", j, locked);
      end
    end
    n_tests++;
    if (period !== 8'd8) begin
      n_fail++; $display("FAIL tol810_period: got %0d want 8", period);
    end
  endtask

  task automatic test_reset_mid();
    int nr;
    do_reset();
    repeat (6) run_period(4, 4);
    slow_in = 1'b1;
    rst     = 1'b1;
    cyc();
    rst     = 1'b0;
    n_tests += 5;
    if (rise_pulse !== 1'b0) begin
      n_fail++; $display("FAIL rmid_rise: got %b want 0", rise_pulse);
    end
    if (fall_pulse !== 1'b0) begin
      n_fail++; $display("FAIL rmid_fall: got %b want 0", fall_pulse);
    end
    if (period !== 8'd0) begin
      n_fail++; $display("FAIL rmid_period: got %0d want 0", period);
    end
    if (locked !== 1'b0) begin
      n_fail++; $display("FAIL rmid_locked: got %b want 0", locked);
    end
    if (lost !== 1'b0) begin
      n_fail++; $display("FAIL rmid_lost: got %b want 0", lost);
    end
    nr = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (rise_pulse === 1'b1) nr++;
      n_tests++;
      if (rise_pulse !== logic'(i == LAT + 1)) begin
        n_fail++;
        $display("FAIL rmid_pulse i %0d: got %b want %b",
                 i, rise_pulse, i == LAT + 1);
      end
    end
    n_tests++;
    if (nr !== 1) begin
      n_fail++; $display("FAIL rmid_count: got %0d want 1", nr);
    end
  endtask

  task automatic test_glitch();
    int nr;
    int nf;
    do_reset();
    repeat (6) run_period(4, 4);
    slow_in = 1'b1;
    cyc();
    slow_in = 1'b0;
    nr = 0;
    nf = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (rise_pulse === 1'b1) nr++;
      if (fall_pulse === 1'b1) nf++;
    end
    n_tests += 4;
    if (nr !== 1 - FILT) begin
      n_fail++; $display("FAIL glitch_rise: got %0d want %0d", nr, 1 - FILT);
    end
    if (nf !== 1 - FILT) begin
      n_fail++; $display("FAIL glitch_fall: got %0d want %0d", nf, 1 - FILT);
    end
    if (period !== 8'd8) begin
      n_fail++; $display("FAIL glitch_period: got %0d want 8", period);
    end
    if (locked !== 1'b1) begin
      n_fail++; $display("FAIL glitch_locked: got %b want 1", locked);
    end
  endtask

  initial begin
    rst     = 1'b1;
    slow_in = 1'b0;
    test_reset();
    test_dead_input();
    test_div8();
    test_lost();
    test_retrack();
    test_tolerance();
    test_reset_mid();
    test_glitch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
